// File: rtl/sdram_types.sv
// Shared command encoding, command-FIFO word layout and request address
// field positions for the SDRAM command generator and its helpers.
package sdram_types;

    // Commands understood by the I/O engine.
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        PALL  = 3'd1,
        REF   = 3'd2,
        MRS   = 3'd3,
        ACT   = 3'd4,
        PRE   = 3'd5,
        READ  = 3'd6,
        WRITE = 3'd7
    } cmd_t;

    // Payload: column plus a 16-bit field that carries the row (ACT),
    // the read tag (READ) or the write data (WRITE).
    typedef struct packed {
        logic [8:0]  column;
        logic [15:0] data;
    } cmd_payload_t;

    // One command-FIFO word.
    typedef struct packed {
        cmd_t         cmd;
        logic [1:0]   ba;
        cmd_payload_t d;
    } data_t;

    // Word address layout: {bank, row, column}.
    localparam int BA_W    = 2;
    localparam int ROW_W   = 13;
    localparam int COL_W   = 9;
    localparam int BA_MSB  = 23;
    localparam int BA_LSB  = 22;
    localparam int ROW_MSB = 21;
    localparam int ROW_LSB = 9;
    localparam int COL_MSB = 8;
    localparam int COL_LSB = 0;

    localparam data_t NOP_WORD = '{cmd: NOP, ba: 2'd0, d: '{column: 9'd0, data: 16'd0}};

    // Assemble a FIFO word from its fields.
    function automatic data_t mk_word(input cmd_t cmd, input logic [BA_W-1:0] ba,
                                      input logic [COL_W-1:0] column, input logic [15:0] data);
        data_t w;
        w.cmd      = cmd;
        w.ba       = ba;
        w.d.column = column;
        w.d.data   = data;
        return w;
    endfunction

endpackage

// File: rtl/sdram_row_tbl.sv
// Per-bank open-row table: one open flag and one row address per bank.
// Lookup is combinational from the flops; updates take effect next cycle.
module sdram_row_tbl
    import sdram_types::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic [BA_W-1:0]  lookup_ba,
    input  logic [ROW_W-1:0] lookup_row,
    output logic             lookup_open,
    output logic             lookup_hit,
    input  logic             set_en,
    input  logic [BA_W-1:0]  set_ba,
    input  logic [ROW_W-1:0] set_row,
    input  logic             clr_en,
    input  logic [BA_W-1:0]  clr_ba,
    input  logic             clr_all
);

    localparam int NBANK = 1 << BA_W;

    logic [NBANK-1:0] open_all;
    logic [ROW_W-1:0] row_all [NBANK];

    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            logic             open_q, open_d;
            logic [ROW_W-1:0] row_q, row_d;

            // Next-state of one bank entry; clear-all wins, then activate, then precharge.
            always_comb begin
                open_d = open_q;
                row_d  = row_q;
                if (clr_all) begin
                    open_d = 1'b0;
                end else if (set_en && (set_ba == BA_W'(gi))) begin
                    open_d = 1'b1;
                    row_d  = set_row;
                end else if (clr_en && (clr_ba == BA_W'(gi))) begin
                    open_d = 1'b0;
                end
            end

            // Entry registers.
            always_ff @(posedge clk) begin
                if (srst) begin
                    open_q <= 1'b0;
                    row_q  <= '0;
                end else begin
                    open_q <= open_d;
                    row_q  <= row_d;
                end
            end

            assign open_all[gi] = open_q;
            assign row_all[gi]  = row_q;
        end
    endgenerate

    assign lookup_open = open_all[lookup_ba];
    assign lookup_hit  = lookup_open && (row_all[lookup_ba] == lookup_row);

endmodule

// File: rtl/sdram_cmd_gen.sv
// SDRAM command generator: power-up init, periodic auto-refresh and
// open-row tracking, turning single-word client requests into the
// command stream for the I/O engine's command FIFO. Timing is enforced
// downstream; this block only orders commands.
module sdram_cmd_gen
    import sdram_types::*;
#(
    parameter int IN        = 4,
    parameter int NREF_INIT = 8,
    parameter int ADDR_W    = 24
) (
    input  logic              clkSDRAM,
    input  logic              reset,
    input  logic              icnt_ovf,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_data,
    input  logic [IN-1:0]     req_id,
    output logic              req_ack,
    output logic              init_done,
    input  logic              fifo_full,
    output logic              fifo_wrreq,
    output data_t             fifo_in
);

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PALL = 4'd1;
    localparam logic [3:0] S_INIT_REF  = 4'd2;
    localparam logic [3:0] S_INIT_MRS  = 4'd3;
    localparam logic [3:0] S_IDLE      = 4'd4;
    localparam logic [3:0] S_REF_PALL  = 4'd5;
    localparam logic [3:0] S_REF_REF   = 4'd6;
    localparam logic [3:0] S_ACC_PRE   = 4'd7;
    localparam logic [3:0] S_ACC_ACT   = 4'd8;
    localparam logic [3:0] S_ACC_OP    = 4'd9;

    localparam logic [2:0] LAST_INIT_REF = 3'(NREF_INIT - 1);

    logic [3:0]  state_q, state_d;
    logic        fifo_wrreq_q, fifo_wrreq_d;
    data_t       fifo_in_q, fifo_in_d;
    logic        req_ack_q, req_ack_d;
    logic        init_done_q, init_done_d;
    logic [1:0]  ref_pend_q, ref_pend_d;
    logic [2:0]  ref_cnt_q, ref_cnt_d;

    logic        ref_dec;
    logic        tbl_open, tbl_hit;
    logic        tbl_set, tbl_clr, tbl_clr_all;

    logic [BA_W-1:0]  req_ba;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    data_t            op_word;

    assign req_ba  = req_addr[BA_MSB:BA_LSB];
    assign req_row = req_addr[ROW_MSB:ROW_LSB];
    assign req_col = req_addr[COL_MSB:COL_LSB];

    // The READ/WRITE word for the current request.
    assign op_word = req_we ? mk_word(WRITE, req_ba, req_col, req_data)
                            : mk_word(READ, req_ba, req_col, 16'(req_id));

    sdram_row_tbl u_row_tbl (
        .clk        (clkSDRAM),
        .srst       (reset),
        .lookup_ba  (req_ba),
        .lookup_row (req_row),
        .lookup_open(tbl_open),
        .lookup_hit (tbl_hit),
        .set_en     (tbl_set),
        .set_ba     (req_ba),
        .set_row    (req_row),
        .clr_en     (tbl_clr),
        .clr_ba     (req_ba),
        .clr_all    (tbl_clr_all)
    );

    // Command sequencing: every emitting state holds while the FIFO is full.
    always_comb begin
        state_d      = state_q;
        fifo_wrreq_d = 1'b0;
        fifo_in_d    = NOP_WORD;
        req_ack_d    = 1'b0;
        init_done_d  = init_done_q;
        ref_cnt_d    = ref_cnt_q;
        ref_dec      = 1'b0;
        tbl_set      = 1'b0;
        tbl_clr      = 1'b0;
        tbl_clr_all  = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                if (icnt_ovf) begin
                    state_d = S_INIT_PALL;
                end
            end
            S_INIT_PALL: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(PALL, '0, '0, '0);
                    ref_cnt_d    = '0;
                    state_d      = S_INIT_REF;
                end
            end
            S_INIT_REF: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(REF, '0, '0, '0);
                    ref_cnt_d    = ref_cnt_q + 3'd1;
                    if (ref_cnt_q == LAST_INIT_REF) begin
                        state_d = S_INIT_MRS;
                    end
                end
            end
            S_INIT_MRS: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(MRS, '0, '0, '0);
                    init_done_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_IDLE: begin
                // Refresh beats the client; decisions wait while the FIFO is full
                // so that ticks arriving meanwhile are still serviced first.
                if (!fifo_full) begin
                    if (ref_pend_q != 2'd0) begin
                        state_d = S_REF_PALL;
                    end else if (req) begin
                        if (tbl_hit) begin
                            fifo_wrreq_d = 1'b1;
                            fifo_in_d    = op_word;
                            req_ack_d    = 1'b1;
                        end else if (tbl_open) begin
                            state_d = S_ACC_PRE;
                        end else begin
                            state_d = S_ACC_ACT;
                        end
                    end
                end
            end
            S_REF_PALL: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(PALL, '0, '0, '0);
                    tbl_clr_all  = 1'b1;
                    state_d      = S_REF_REF;
                end
            end
            S_REF_REF: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(REF, '0, '0, '0);
                    ref_dec      = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_ACC_PRE: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(PRE, req_ba, '0, '0);
                    tbl_clr      = 1'b1;
                    state_d      = S_ACC_ACT;
                end
            end
            S_ACC_ACT: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = mk_word(ACT, req_ba, '0, 16'(req_row));
                    tbl_set      = 1'b1;
                    state_d      = S_ACC_OP;
                end
            end
            S_ACC_OP: begin
                if (!fifo_full) begin
                    fifo_wrreq_d = 1'b1;
                    fifo_in_d    = op_word;
                    req_ack_d    = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
            end
        endcase
    end

    // Pending-refresh counter: ticks after init add, emitted REFs subtract, saturating at 3.
    always_comb begin
        ref_pend_d = ref_pend_q;
        case ({icnt_ovf && init_done_q, ref_dec})
            2'b10:   if (ref_pend_q != 2'd3) ref_pend_d = ref_pend_q + 2'd1;
            2'b01:   ref_pend_d = ref_pend_q - 2'd1;
            default: ref_pend_d = ref_pend_q;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clkSDRAM) begin
        if (reset) begin
            state_q      <= S_INIT_WAIT;
            fifo_wrreq_q <= 1'b0;
            fifo_in_q    <= NOP_WORD;
            req_ack_q    <= 1'b0;
            init_done_q  <= 1'b0;
            ref_pend_q   <= 2'd0;
            ref_cnt_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            fifo_in_q    <= fifo_in_d;
            req_ack_q    <= req_ack_d;
            init_done_q  <= init_done_d;
            ref_pend_q   <= ref_pend_d;
            ref_cnt_q    <= ref_cnt_d;
        end
    end

    assign fifo_wrreq = fifo_wrreq_q;
    assign fifo_in    = fifo_in_q;
    assign req_ack    = req_ack_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_sdram_cmd_gen.sv
// Bench for sdram_cmd_gen: expected FIFO words are queued when stimulus is
// driven and checked in order by a monitor as the DUT writes them.
`timescale 1ns/1ps
module tb_sdram_cmd_gen;
    import sdram_types::*;

    logic        clk = 1'b0;
    logic        reset, icnt_ovf, req, req_we, fifo_full;
    logic [23:0] req_addr;
    logic [15:0] req_data;
    logic [3:0]  req_id;
    logic        req_ack, init_done, fifo_wrreq;
    data_t       fifo_in;

    int    checks   = 0;
    int    failures = 0;
    int    ack_cnt  = 0;
    int    cyc      = 0;
    data_t exp_q[$];
    data_t exp_w;
    logic  full_at_edge = 1'b0;
    logic  exp_ack;

    always #5 clk = ~clk;

    sdram_cmd_gen #(.IN(4), .NREF_INIT(8), .ADDR_W(24)) dut (
        .clkSDRAM  (clk),
        .reset     (reset),
        .icnt_ovf  (icnt_ovf),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_id    (req_id),
        .req_ack   (req_ack),
        .init_done (init_done),
        .fifo_full (fifo_full),
        .fifo_wrreq(fifo_wrreq),
        .fifo_in   (fifo_in)
    );

    function automatic data_t mk(input cmd_t c, input logic [1:0] ba,
                                 input logic [8:0] col, input logic [15:0] d);
        data_t w;
        w.cmd = c; w.ba = ba; w.d.column = col; w.d.data = d;
        return w;
    endfunction

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        full_at_edge <= fifo_full;
    end

    // Scoreboard monitor: one line per FIFO write.
    always @(negedge clk) begin
        if (fifo_wrreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got=%h (cmd=%s) required=none", fifo_in, fifo_in.cmd.name());
            end else begin
                exp_w = exp_q.pop_front();
                if (fifo_in !== exp_w) begin
                    failures++;
                    $display("FAIL word got=%h (cmd=%s) required=%h (cmd=%s)",
                             fifo_in, fifo_in.cmd.name(), exp_w, exp_w.cmd.name());
                end else begin
                    $display("word cmd=%s ba=%0d col=%h data=%h", fifo_in.cmd.name(),
                             fifo_in.ba, fifo_in.d.column, fifo_in.d.data);
                end
            end
            checks++;
            if (full_at_edge) begin
                failures++;
                $display("FAIL write_while_full got=1 required=0");
            end
            checks++;
            exp_ack = (fifo_in.cmd == READ) || (fifo_in.cmd == WRITE);
            if (req_ack !== exp_ack) begin
                failures++;
                $display("FAIL ack_with_word got=%b required=%b", req_ack, exp_ack);
            end
            if (fifo_in.cmd == MRS) begin
                checks++;
                if (init_done !== 1'b1) begin
                    failures++;
                    $display("FAIL init_done_with_mrs got=%b required=1", init_done);
                end
            end
        end else if (req_ack) begin
            checks++;
            failures++;
            $display("FAIL ack_without_word got=1 required=0");
        end
        if (req_ack) ack_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req_v);
        checks++;
        if (got !== req_v) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req_v);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got=%0d_words_left required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack !== 1'b1 && n < 200);
        checks++;
        if (req_ack !== 1'b1) begin
            failures++;
            $display("FAIL %s_ack_timeout got=0 required=1", name);
        end
    endtask

    task automatic set_req(input logic we, input logic [23:0] a, input logic [15:0] d, input logic [3:0] id);
        req = 1'b1; req_we = we; req_addr = a; req_data = d; req_id = id;
    endtask

    task automatic tick();
        @(negedge clk); icnt_ovf = 1'b1;
        @(negedge clk); icnt_ovf = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
        exp_q.push_back(mk(MRS, 2'd0, 9'd0, 16'd0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fifo_wrreq"}, 32'(fifo_wrreq), 32'd0);
        chk({tag, "_fifo_in"}, 32'(fifo_in), 32'(mk(NOP, 2'd0, 9'd0, 16'd0)));
        chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
        logic [3:0]  id;
        logic [1:0]  n;
        data_t       w0;
        data_t       w1;
        data_t       w2;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int ack0;
        int t [4];
        data_t w;

        vec[0] = '{we: 1'b0, addr: 24'h401205, data: 16'h0000, id: 4'h3, n: 2'd2,
                   w0: mk(ACT, 2'd1, 9'd0, 16'h0009), w1: mk(READ, 2'd1, 9'h005, 16'h0003), w2: '0};
        vec[1] = '{we: 1'b1, addr: 24'h401206, data: 16'hBEEF, id: 4'h0, n: 2'd1,
                   w0: mk(WRITE, 2'd1, 9'h006, 16'hBEEF), w1: '0, w2: '0};
        vec[2] = '{we: 1'b0, addr: 24'h403000, data: 16'h0000, id: 4'h7, n: 2'd3,
                   w0: mk(PRE, 2'd1, 9'd0, 16'd0), w1: mk(ACT, 2'd1, 9'd0, 16'h0018),
                   w2: mk(READ, 2'd1, 9'h000, 16'h0007)};
        vec[3] = '{we: 1'b1, addr: 24'h800010, data: 16'h1234, id: 4'h0, n: 2'd2,
                   w0: mk(ACT, 2'd2, 9'd0, 16'h0000), w1: mk(WRITE, 2'd2, 9'h010, 16'h1234), w2: '0};
        vec[4] = '{we: 1'b0, addr: 24'h800011, data: 16'h0000, id: 4'hA, n: 2'd1,
                   w0: mk(READ, 2'd2, 9'h011, 16'h000A), w1: '0, w2: '0};
        vec[5] = '{we: 1'b1, addr: 24'h000200, data: 16'h5555, id: 4'h0, n: 2'd2,
                   w0: mk(ACT, 2'd0, 9'd0, 16'h0001), w1: mk(WRITE, 2'd0, 9'h000, 16'h5555), w2: '0};
        vec[6] = '{we: 1'b0, addr: 24'h4031FF, data: 16'h0000, id: 4'hF, n: 2'd1,
                   w0: mk(READ, 2'd1, 9'h1FF, 16'h000F), w1: '0, w2: '0};
        vec[7] = '{we: 1'b1, addr: 24'hFFFFFF, data: 16'hFFFF, id: 4'h0, n: 2'd2,
                   w0: mk(ACT, 2'd3, 9'd0, 16'h1FFF), w1: mk(WRITE, 2'd3, 9'h1FF, 16'hFFFF), w2: '0};

        reset = 1'b1; icnt_ovf = 1'b0; fifo_full = 1'b0;
        req = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_id = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Init: request held throughout must not be acknowledged.
        set_req(1'b0, 24'h000200, 16'h0, 4'h1);
        repeat (20) @(negedge clk);
        chk("init_done_before_tick", 32'(init_done), 32'd0);
        push_init();
        tick();
        wait_drain("init", 100);
        req = 1'b0;
        chk("init_no_ack", 32'(ack_cnt), 32'd0);
        chk("init_done_after", 32'(init_done), 32'd1);

        // Table-driven single accesses.
        for (int i = 0; i < NV; i++) begin
            ack0 = ack_cnt;
            exp_q.push_back(vec[i].w0);
            if (vec[i].n > 2'd1) exp_q.push_back(vec[i].w1);
            if (vec[i].n > 2'd2) exp_q.push_back(vec[i].w2);
            set_req(vec[i].we, vec[i].addr, vec[i].data, vec[i].id);
            wait_ack($sformatf("vec%0d", i));
            req = 1'b0;
            wait_drain($sformatf("vec%0d", i), 20);
            repeat (2) @(negedge clk); #1;
            chk($sformatf("vec%0d_ack_count", i), 32'(ack_cnt - ack0), 32'd1);
        end

        // Back-to-back same-row hits: one word per cycle.
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(READ, 2'd3, 9'h1F0 + 9'(i), 16'(i)));
        set_req(1'b0, 24'hFFFFF0, 16'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("burst%0d", i));
            t[i] = cyc;
            if (i < 3) set_req(1'b0, 24'hFFFFF0 + 24'(i + 1), 16'h0, 4'(i + 1));
            else req = 1'b0;
        end
        wait_drain("burst", 10);
        chk("burst_span", 32'(t[3] - t[0]), 32'd3);

        // Two ticks while the FIFO is full and a request waits: refresh first.
        @(negedge clk); fifo_full = 1'b1;
        ack0 = ack_cnt;
        set_req(1'b0, 24'h403000, 16'h0, 4'h5);
        tick();
        @(negedge clk);
        tick();
        repeat (3) @(negedge clk);
        chk("full_no_write", 32'(fifo_wrreq), 32'd0);
        exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
        exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
        exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
        exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
        exp_q.push_back(mk(ACT, 2'd1, 9'd0, 16'h0018));
        exp_q.push_back(mk(READ, 2'd1, 9'h000, 16'h0005));
        fifo_full = 1'b0;
        wait_ack("refresh_access");
        req = 1'b0;
        wait_drain("refresh", 20);
        repeat (10) @(negedge clk); #1;
        chk("refresh_ack_count", 32'(ack_cnt - ack0), 32'd1);

        // Four ticks while full: pending count saturates at three.
        @(negedge clk); fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
            exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
        end
        @(negedge clk); fifo_full = 1'b0;
        wait_drain("saturate", 40);
        repeat (10) @(negedge clk); #1;
        chk("saturate_queue_empty", 32'(exp_q.size()), 32'd0);

        // Open bank 0 row 1, then reset in the middle of a row-miss sequence.
        exp_q.push_back(mk(ACT, 2'd0, 9'd0, 16'h0001));
        exp_q.push_back(mk(READ, 2'd0, 9'h000, 16'h0002));
        set_req(1'b0, 24'h000200, 16'h0, 4'h2);
        wait_ack("open_bank0");
        req = 1'b0;
        wait_drain("open_bank0", 20);
        ack0 = ack_cnt;
        exp_q.push_back(mk(PRE, 2'd0, 9'd0, 16'd0));
        set_req(1'b1, 24'h000400, 16'hAAAA, 4'h0);
        wait_drain("mid_pre", 20);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        req = 1'b0;
        repeat (10) @(negedge clk); #1;
        chk("midreset_no_ack", 32'(ack_cnt - ack0), 32'd0);
        chk("midreset_no_init", 32'(init_done), 32'd0);

        push_init();
        tick();
        wait_drain("reinit", 100);

        // Row table was cleared by reset: bank 0 needs a fresh ACT.
        exp_q.push_back(mk(ACT, 2'd0, 9'd0, 16'h0001));
        exp_q.push_back(mk(READ, 2'd0, 9'h000, 16'h0009));
        set_req(1'b0, 24'h000200, 16'h0, 4'h9);
        wait_ack("post_reset");
        req = 1'b0;
        wait_drain("post_reset", 20);
        repeat (5) @(negedge clk); #1;
        w = mk(NOP, 2'd0, 9'd0, 16'd0);
        chk("final_fifo_in_nop", 32'(fifo_in), 32'(w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_gen.md
Name: sdram_cmd_gen

Overview:
Command-side initiator for the SDRAM I/O engine. It owns power-up initialisation, periodic auto-refresh and per-bank open-row tracking. It translates single-client word read/write requests into the data_t command stream written to the command FIFO that the I/O engine drains. All timing (tRCD, tRP, tRC, …) is enforced downstream by I/O-engine stalls; this block only orders commands correctly.

Parameters:
IN, 4, width of read request ID returned with read data
NREF_INIT, 8, number of REF commands issued during initialisation
ADDR_W, 24, word address width = 2 bank + 13 row + 9 column

Ports:
clkSDRAM  in  1  SDRAM clock; single clock domain
reset  in  1  synchronous, active-high reset
icnt_ovf  in  1  one-cycle tick from the I/O engine periodic counter (first tick = init delay elapsed, then refresh interval)
req  in  1  request valid; held stable until req_ack
req_we  in  1  1 = write, 0 = read
req_addr  in  24  {ba[23:22], row[21:9], column[8:0]}
req_data  in  16  write data
req_id  in  IN  read tag, returned by the I/O engine with the burst
req_ack  out  1  one-cycle pulse when the request's READ/WRITE word enters the FIFO
init_done  out  1  high once MRS has been queued
fifo_full  in  1  command FIFO full
fifo_wrreq  out  1  FIFO write strobe
fifo_in  out  data_t  command word {cmd, ba, d{column[8:0], data[15:0]}}

Behaviour:
- Reset: fifo_wrreq=0, fifo_in={NOP,0,0}, req_ack=0, init_done=0, all open flags=0, ref_pend=0, state=INIT_WAIT. Reset mid-operation abandons any partial sequence. Words already in the FIFO are not recalled.
- Emission rule: a word is written only in a cycle where fifo_full=0. fifo_wrreq and fifo_in are registered (1-cycle latency from decision). When fifo_full=1, the state machine holds and fifo_wrreq=0.
- Word encoding:
  - ACT: ba, d.data[12:0]=row.
  - READ: ba, d.column, d.data[IN-1:0]=req_id.
  - WRITE: ba, d.column, d.data=req_data.
  - PRE: ba.
  - PALL, REF, MRS: ba=0, d=0.
- Init states:
  - INIT_WAIT waits for the first icnt_ovf; that tick is not counted as a refresh.
  - INIT_PALL emits PALL.
  - INIT_REF emits NREF_INIT REFs (3-bit counter).
  - INIT_MRS emits MRS, sets init_done, then goes to IDLE.
  - req is ignored (no ack) until init_done.
- Refresh:
  - ref_pend is a 2-bit counter. It increments on each icnt_ovf after init and saturates at 3.
  - Each REF emitted decrements it. A tick in the same cycle as a REF leaves it unchanged.
- IDLE priority: ref_pend!=0 beats req.
- Refresh sequence: REF_PALL emits PALL and clears all open flags, then REF_REF emits REF and returns to IDLE.
- Access path (bank b = req_addr[23:22], row r):
  - open[b] and row[b]==r: emit READ/WRITE, pulse req_ack.
  - open[b] and row[b]!=r: emit PRE(b), then ACT(b,r), then READ/WRITE.
  - !open[b]: emit ACT(b,r), then READ/WRITE.
  - ACT sets open[b]=1, row[b]=r. PRE clears open[b].
- States: INIT_WAIT, INIT_PALL, INIT_REF, INIT_MRS, IDLE, REF_PALL, REF_REF, ACC_PRE, ACC_ACT, ACC_OP.
- Once ACC_PRE is entered, the access completes before a pending refresh is serviced. Refresh is checked only in IDLE.
- req_ack is asserted in the cycle the OP word is accepted (fifo_wrreq registered high). The client may present the next request the following cycle. Back-to-back same-row hits sustain one word per cycle.
- icnt_ovf during INIT states after the first tick is ignored.

Decomposition:
- Package sdram_types holds:
  - cmd_t enum (NOP, PALL, REF, MRS, ACT, PRE, READ, WRITE).
  - data_t packed struct {cmd_t cmd; logic [1:0] ba; struct {column[8:0], data[15:0]} d}.
  - localparams for address field slices.
- One sub-module, sdram_row_tbl: 4-entry open/row table with lookup (hit, open) and set/clear/clear-all ports.

Test Plan:
- Reset, then icnt_ovf after 20 cycles -> FIFO sequence exactly PALL, 8×REF, MRS; init_done rises with MRS; req held high throughout gets no ack.
- Read 0x40_1205 on closed bank 1 -> ACT(ba=1,row=0x009), READ(ba=1,col=0x005,id); ack once.
- Write 0x40_1206 data 0xBEEF after previous -> single WRITE(ba=1,col=0x006,data=0xBEEF); no ACT.
- Read 0x40_3000 (bank 1, row 0x018) -> PRE(1), ACT(1,0x018), READ.
- icnt_ovf twice while fifo_full=1 and req pending -> after full deasserts: PALL, REF, PALL, REF before the access's ACT (row table cleared); ref_pend returns to 0.
- Assert reset midway through PRE/ACT/OP -> outputs return to reset values next cycle, no ack; init sequence restarts on next icnt_ovf.
